// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller state encoding, default MISR constants
// and the Galois MISR step used by compaction and pattern-generation blocks.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_e;

    localparam int          MISR_MAX_W    = 32;
    localparam logic [15:0] BIST_POLY_DEF = 16'h100B;
    localparam logic [15:0] BIST_SEED_DEF = 16'h0000;

    // Operands are zero-extended to MISR_MAX_W; only the low sig_w bits are meaningful.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] vec,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           sig_w
    );
        logic [MISR_MAX_W-1:0] mask_v;
        logic                  msb_v;
        logic [MISR_MAX_W-1:0] res_v;
        if (sig_w >= MISR_MAX_W) begin
            mask_v = {MISR_MAX_W{1'b1}};
        end else begin
            mask_v = (32'd1 << sig_w) - 32'd1;
        end
        msb_v = |(sig & (32'd1 << (sig_w - 32'd1)));
        res_v = (sig << 1) ^ (msb_v ? poly : {MISR_MAX_W{1'b0}}) ^ vec;
        return res_v & mask_v;
    endfunction

endpackage

// File: rtl/bist_misr_core.sv
// Multiple-input signature register: load restores SEED, enable folds in one vector.
module bist_misr_core
    import bist_pkg::*;
#(
    parameter int                WIDTH = 7,
    parameter int                SIG_W = 16,
    parameter logic [SIG_W-1:0]  POLY  = SIG_W'(BIST_POLY_DEF),
    parameter logic [SIG_W-1:0]  SEED  = SIG_W'(BIST_SEED_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] vec,
    output logic [SIG_W-1:0] signature,
    output logic [SIG_W-1:0] sig_next
);

    logic [SIG_W-1:0]      sig_r;
    logic [MISR_MAX_W-1:0] sig_ext_s;
    logic [MISR_MAX_W-1:0] vec_ext_s;
    logic [MISR_MAX_W-1:0] poly_ext_s;
    logic [MISR_MAX_W-1:0] step_s;

    assign sig_ext_s  = MISR_MAX_W'(sig_r);
    assign vec_ext_s  = MISR_MAX_W'(vec);
    assign poly_ext_s = MISR_MAX_W'(POLY);
    assign step_s     = misr_step(sig_ext_s, vec_ext_s, poly_ext_s, SIG_W);
    assign sig_next   = step_s[SIG_W-1:0];
    assign signature  = sig_r;

    generate
        if (SIG_W < MISR_MAX_W) begin : g_hi
            logic unused_hi_s;
            assign unused_hi_s = ^step_s[MISR_MAX_W-1:SIG_W];
        end
    endgenerate

    // Signature register; load takes priority over a compaction step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= SEED;
        end else if (load) begin
            sig_r <= SEED;
        end else if (enable) begin
            sig_r <= sig_next;
        end else begin
            sig_r <= sig_r;
        end
    end

endmodule

// File: rtl/bist_resp_misr.sv
// BIST response compactor: windowed MISR with golden-signature compare.
// Optional macro BIST_RESP_MASK_EN adds resp_mask to blank unknown response bits.
module bist_resp_misr
    import bist_pkg::*;
#(
    parameter int                WIDTH = 7,
    parameter int                SIG_W = 16,
    parameter int                CNT_W = 16,
    parameter logic [SIG_W-1:0]  POLY  = SIG_W'(BIST_POLY_DEF),
    parameter logic [SIG_W-1:0]  SEED  = SIG_W'(BIST_SEED_DEF)
) (
    input  logic             CK,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
`ifdef BIST_RESP_MASK_EN
    input  logic [WIDTH-1:0] resp_mask,
`endif
    input  logic [SIG_W-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    bist_state_e      state_r;
    bist_state_e      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] num_r;
    logic             pass_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             step_s;
    logic             last_s;
    logic [WIDTH-1:0] vec_s;
    logic [SIG_W-1:0] sig_next_s;

`ifdef BIST_RESP_MASK_EN
    assign vec_s = resp & ~resp_mask;
`else
    assign vec_s = resp;
`endif

    assign last_s = (cnt_r == (num_r - CNT_ONE));

    bist_misr_core #(
        .WIDTH (WIDTH),
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk       (CK),
        .rst_n     (rst_n),
        .load      (load_s),
        .enable    (step_s),
        .vec       (vec_s),
        .signature (signature),
        .sig_next  (sig_next_s)
    );

    // Next-state and datapath strobes; start is only honoured outside RUN.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = (num_cycles == CNT_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (resp_valid) begin
                    step_s      = 1'b1;
                    state_nxt_s = last_s ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus flopped status outputs decoded from the next state.
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Window counter and latched window length.
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
            num_r <= CNT_ZERO;
        end else if (load_s) begin
            cnt_r <= CNT_ZERO;
            num_r <= num_cycles;
        end else if (step_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            num_r <= num_r;
        end else begin
            cnt_r <= cnt_r;
            num_r <= num_r;
        end
    end

    // Golden compare; an empty window reports on the start edge against SEED.
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            pass_r <= 1'b0;
        end else if (load_s) begin
            pass_r <= (num_cycles == CNT_ZERO) ? (SEED == golden) : 1'b0;
        end else if (step_s && last_s) begin
            pass_r <= (sig_next_s == golden);
        end else begin
            pass_r <= pass_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign pass = pass_r;

endmodule

// File: tb/tb_bist_resp_misr.sv
// Self-checking bench for bist_resp_misr: vector table with scoreboard plus
// hand-written reset, feedback, restart and abort sequences.
module tb_bist_resp_misr;

    logic        CK = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_cycles;
    logic        resp_valid;
    logic [6:0]  resp;
    logic [15:0] golden;
    logic        busy, done, pass;
    logic [15:0] signature;
    logic        busy_s, done_s, pass_s;
    logic [15:0] signature_s;
`ifdef BIST_RESP_MASK_EN
    logic [6:0]  resp_mask;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    bist_resp_misr dut (
        .CK (CK), .rst_n (rst_n), .start (start), .num_cycles (num_cycles),
        .resp_valid (resp_valid), .resp (resp),
`ifdef BIST_RESP_MASK_EN
        .resp_mask (resp_mask),
`endif
        .golden (golden), .busy (busy), .done (done), .pass (pass),
        .signature (signature)
    );

    bist_resp_misr #(.SEED (16'h8000)) dut_s (
        .CK (CK), .rst_n (rst_n), .start (start), .num_cycles (num_cycles),
        .resp_valid (resp_valid), .resp (resp),
`ifdef BIST_RESP_MASK_EN
        .resp_mask (resp_mask),
`endif
        .golden (golden), .busy (busy_s), .done (done_s), .pass (pass_s),
        .signature (signature_s)
    );

    typedef struct packed {
        logic [15:0]      num;
        logic [3:0]       stall;
        logic [15:0]      golden;
        logic [19:0][6:0] vecs;
        logic [15:0]      exp_sig;
        logic             exp_pass;
    } vec_rec_t;

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
    } exp_t;

    vec_rec_t tbl [7];
    exp_t     sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Entered 1 time unit after a rising edge.
    task automatic run_window(input vec_rec_t r);
        exp_t e;
        e.sig  = r.exp_sig;
        e.pass = r.exp_pass;
        sb_q.push_back(e);
        start = 1'b1; num_cycles = r.num; golden = r.golden;
        tick();
        start = 1'b0;
        for (int k = 0; k < int'(r.num); k++) begin
            chk("busy_in_run", {31'd0, busy}, 32'd1);
            chk("done_in_run", {31'd0, done}, 32'd0);
            resp_valid = 1'b1; resp = r.vecs[k];
            tick();
            resp_valid = 1'b0; resp = 7'h00;
            if (k < int'(r.num) - 1) begin
                for (int s = 0; s < int'(r.stall); s++) begin
                    chk("done_in_stall", {31'd0, done}, 32'd0);
                    tick();
                end
            end
        end
        chk("done_latency", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        e = sb_q.pop_front();
        chk("signature", {16'd0, signature}, {16'd0, e.sig});
        chk("pass", {31'd0, pass}, {31'd0, e.pass});
    endtask

    initial begin
        for (int i = 0; i < 7; i++) tbl[i] = '0;
        tbl[0].num = 16'd1; tbl[0].golden = 16'h0001; tbl[0].vecs[0] = 7'h01;
        tbl[0].exp_sig = 16'h0001; tbl[0].exp_pass = 1'b1;
        tbl[1].num = 16'd2; tbl[1].stall = 4'd3; tbl[1].golden = 16'h0002;
        tbl[1].vecs[0] = 7'h01; tbl[1].vecs[1] = 7'h00;
        tbl[1].exp_sig = 16'h0002; tbl[1].exp_pass = 1'b1;
        tbl[2].num = 16'd3; tbl[2].golden = 16'h0000;
        tbl[2].vecs[0] = 7'h01; tbl[2].vecs[1] = 7'h02; tbl[2].vecs[2] = 7'h03;
        tbl[2].exp_sig = 16'h0003; tbl[2].exp_pass = 1'b0;
        tbl[3].num = 16'd4; tbl[3].stall = 4'd1; tbl[3].golden = 16'h022A;
        tbl[3].vecs[0] = 7'h55; tbl[3].vecs[1] = 7'h2A; tbl[3].vecs[2] = 7'h11; tbl[3].vecs[3] = 7'h08;
        tbl[3].exp_sig = 16'h022A; tbl[3].exp_pass = 1'b1;
        tbl[4].num = 16'd17; tbl[4].golden = 16'h100B; tbl[4].vecs[0] = 7'h01;
        tbl[4].exp_sig = 16'h100B; tbl[4].exp_pass = 1'b1;
        tbl[5].num = 16'd2; tbl[5].golden = 16'h1234;
        tbl[5].vecs[0] = 7'h7F; tbl[5].vecs[1] = 7'h7F;
        tbl[5].exp_sig = 16'h0081; tbl[5].exp_pass = 1'b0;
        tbl[6].num = 16'd0; tbl[6].golden = 16'h0000;
        tbl[6].exp_sig = 16'h0000; tbl[6].exp_pass = 1'b1;

        rst_n = 1'b0; start = 1'b0; num_cycles = 16'd0; resp_valid = 1'b0;
        resp = 7'h00; golden = 16'h0000;
`ifdef BIST_RESP_MASK_EN
        resp_mask = 7'h00;
`endif
        #2;
        chk("rst_signature", {16'd0, signature}, 32'h0000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_window(tbl[i]);
            tick();
        end
        chk("zero_win_seed_s", {16'd0, signature_s}, 32'h8000);
        chk("zero_win_done_s", {31'd0, done_s}, 32'd1);

        // Restart from DONE; a start pulse inside RUN must be ignored.
        start = 1'b1; num_cycles = 16'd3; golden = 16'h0003;
        tick();
        start = 1'b0;
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_done", {31'd0, done}, 32'd0);
        resp_valid = 1'b1; resp = 7'h01;
        tick();
        start = 1'b1; num_cycles = 16'd0; resp = 7'h02;
        tick();
        start = 1'b0;
        chk("start_in_run_busy", {31'd0, busy}, 32'd1);
        resp = 7'h03;
        tick();
        resp_valid = 1'b0;
        chk("restart_end_done", {31'd0, done}, 32'd1);
        chk("restart_end_sig", {16'd0, signature}, 32'h0003);
        chk("restart_end_pass", {31'd0, pass}, 32'd1);
        tick();

        // Feedback path through the SEED=8000 instance.
        start = 1'b1; num_cycles = 16'd1; golden = 16'h100B;
        tick();
        start = 1'b0; resp_valid = 1'b1; resp = 7'h00;
        tick();
        resp_valid = 1'b0;
        chk("fb_sig_s", {16'd0, signature_s}, 32'h100B);
        chk("fb_pass_s", {31'd0, pass_s}, 32'd1);
        chk("fb_done_s", {31'd0, done_s}, 32'd1);
        chk("fb_sig", {16'd0, signature}, 32'h0000);
        chk("fb_pass", {31'd0, pass}, 32'd0);
        start = 1'b1; golden = 16'h0000;
        tick();
        start = 1'b0; resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        chk("fb2_sig_s", {16'd0, signature_s}, 32'h100B);
        chk("fb2_pass_s", {31'd0, pass_s}, 32'd0);
        chk("fb2_pass", {31'd0, pass}, 32'd1);
        tick();

        // Reset asserted after 2 of 5 vectors.
        start = 1'b1; num_cycles = 16'd5; golden = 16'h0000;
        tick();
        start = 1'b0; resp_valid = 1'b1; resp = 7'h01;
        repeat (2) tick();
        chk("pre_abort_sig", {16'd0, signature}, 32'h0003);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sig", {16'd0, signature}, 32'h0000);
        chk("abort_sig_s", {16'd0, signature_s}, 32'h8000);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_pass", {31'd0, pass}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        resp_valid = 1'b0;
        chk("post_abort_done", {31'd0, done}, 32'd0);
        chk("post_abort_busy", {31'd0, busy}, 32'd0);
        chk("post_abort_sig", {16'd0, signature}, 32'h0000);

`ifdef BIST_RESP_MASK_EN
        begin
            vec_rec_t m;
            m = '0;
            m.num = 16'd1; m.golden = 16'h0001; m.vecs[0] = 7'h7F;
            m.exp_sig = 16'h0001; m.exp_pass = 1'b1;
            resp_mask = 7'h7E;
            run_window(m);
            resp_mask = 7'h00;
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
